// File: rtl/mp3_pkg.sv
// rtl/mp3_pkg.sv - shared constants and state types for the MP3 window partial-sum stage
package mp3_pkg;

    localparam int IN_W      = 16;               // windowed sample width, signed
    localparam int OUT_W     = IN_W + 3;         // partial-sum width; 8 taps need 3 guard bits
    localparam int NSUB      = 64;               // partial sums per frame
    localparam int NTAP      = 8;                // samples summed per partial sum
    localparam int FRAME_LEN = NSUB * NTAP;      // 512 windowed samples per frame
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam int IDX_W     = $clog2(NSUB);

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } bank_state_e;

    typedef enum logic {
        IDLE,
        DRAIN
    } out_state_e;

endpackage

// File: rtl/psum_bank.sv
// rtl/psum_bank.sv - 64-entry partial-sum register bank, one read-modify-write port, one read port
//
// Ports:
//   clk_i     clock
//   we_i      write strobe for waddr_i
//   first_i   first tap of the frame: overwrite instead of accumulate
//   waddr_i   partial-sum index being updated
//   wdata_i   signed windowed sample to add
//   raddr_i   read index
//   rdata_o   combinational read data
module psum_bank
    import mp3_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic                    first_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic signed [IN_W-1:0]  wdata_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic signed [OUT_W-1:0] rdata_o
);

    logic signed [OUT_W-1:0] mem_q [NSUB];
    logic signed [OUT_W-1:0] wsext;

    assign wsext = {{(OUT_W-IN_W){wdata_i[IN_W-1]}}, wdata_i};

    // The first tap overwrites, so a bank never needs a clear pass between frames.
    // Contents are deliberately not reset: bank state in the top decides validity.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= first_i ? wsext : mem_q[waddr_i] + wsext;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/window_partial_sum.sv
// rtl/window_partial_sum.sv - forms Y[i] = sum_j Z[i+64j] into ping-pong banks and streams Y[0..63] out
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   wso        windowed sample Z[n], signed
//   wso_valid  qualifies wso, one sample per cycle at most, no backpressure
//   y_data     partial sum Y[y_idx], signed
//   y_idx      index of y_data
//   y_valid    y_data/y_idx/y_last valid
//   y_ready    downstream accepts on y_valid & y_ready
//   y_last     high with y_idx == 63
//   overrun    sticky: a whole frame was dropped because no bank was free
module window_partial_sum
    import mp3_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  wso,
    input  logic                    wso_valid,
    output logic signed [OUT_W-1:0] y_data,
    output logic [IDX_W-1:0]        y_idx,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic                    y_last,
    output logic                    overrun
);

    logic [CNT_W-1:0]        in_cnt_q,  in_cnt_d;
    logic                    frame_ok_q, frame_ok_d;
    logic                    wr_bank_q, wr_bank_d;
    logic                    rd_bank_q, rd_bank_d;
    logic                    overrun_q, overrun_d;
    bank_state_e             bank_st_q [2];
    bank_state_e             bank_st_d [2];
    out_state_e              out_st_q,  out_st_d;
    logic                    y_valid_q, y_valid_d;
    logic [IDX_W-1:0]        y_idx_q,   y_idx_d;
    logic signed [OUT_W-1:0] y_data_q,  y_data_d;
    logic                    y_last_q,  y_last_d;

    logic                    frame_start;
    logic                    frame_end;
    logic                    hs;
    logic                    free_rd;
    logic                    wr_free;
    logic                    accept_now;
    logic                    wr_en;
    logic                    first_tap;
    logic                    rd_sel;
    logic [IDX_W-1:0]        rd_addr;
    logic signed [OUT_W-1:0] rdata0;
    logic signed [OUT_W-1:0] rdata1;
    logic signed [OUT_W-1:0] rd_data;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    assign frame_start = wso_valid && (in_cnt_q == '0);
    assign frame_end   = wso_valid && (in_cnt_q == CNT_W'(FRAME_LEN - 1));
    assign hs          = y_valid_q && y_ready;
    assign free_rd     = (out_st_q == DRAIN) && hs && (y_idx_q == IDX_W'(NSUB - 1));

    // A bank released by the final output handshake this cycle counts as free,
    // so a frame starting on it in the same cycle is still accepted.
    assign wr_free    = (bank_st_q[wr_bank_q] == EMPTY) ||
                        (free_rd && (rd_bank_q == wr_bank_q));
    assign accept_now = frame_start && wr_free;
    assign wr_en      = wso_valid && (frame_start ? wr_free : frame_ok_q);
    assign first_tap  = (in_cnt_q[CNT_W-1:IDX_W] == '0);

    always_comb begin
        in_cnt_d   = in_cnt_q;
        frame_ok_d = frame_ok_q;
        wr_bank_d  = wr_bank_q;
        overrun_d  = overrun_q;
        bank_st_d  = bank_st_q;

        if (wso_valid) begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
        end
        if (frame_start) begin
            frame_ok_d = wr_free;
            if (!wr_free) begin
                overrun_d = 1'b1;
            end
        end

        // Ordering matters: release first, then claim, then complete.
        if (free_rd) begin
            bank_st_d[rd_bank_q] = EMPTY;
        end
        if (accept_now) begin
            bank_st_d[wr_bank_q] = FILL;
        end
        if (wr_en && frame_end) begin
            bank_st_d[wr_bank_q] = FULL;
            wr_bank_d            = ~wr_bank_q;
        end
    end

    // ------------------------------------------------------------------
    // Banks
    // ------------------------------------------------------------------
    // Look-ahead read: fetch the entry that will be shown after the next
    // handshake. On the last beat it switches to entry 0 of the other bank.
    assign rd_sel  = rd_bank_q ^ free_rd;
    assign rd_addr = (out_st_q == DRAIN) ? y_idx_q + IDX_W'(1) : '0;
    assign rd_data = rd_sel ? rdata1 : rdata0;

    psum_bank u_bank0 (
        .clk_i   (clk),
        .we_i    (wr_en && !wr_bank_q),
        .first_i (first_tap),
        .waddr_i (in_cnt_q[IDX_W-1:0]),
        .wdata_i (wso),
        .raddr_i (rd_addr),
        .rdata_o (rdata0)
    );

    psum_bank u_bank1 (
        .clk_i   (clk),
        .we_i    (wr_en && wr_bank_q),
        .first_i (first_tap),
        .waddr_i (in_cnt_q[IDX_W-1:0]),
        .wdata_i (wso),
        .raddr_i (rd_addr),
        .rdata_o (rdata1)
    );

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    always_comb begin
        out_st_d  = out_st_q;
        rd_bank_d = rd_bank_q;
        y_valid_d = y_valid_q;
        y_idx_d   = y_idx_q;
        y_data_d  = y_data_q;
        y_last_d  = y_last_q;

        unique case (out_st_q)
            IDLE: begin
                if (bank_st_q[rd_bank_q] == FULL) begin
                    out_st_d  = DRAIN;
                    y_valid_d = 1'b1;
                    y_idx_d   = '0;
                    y_data_d  = rd_data;
                    y_last_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (y_idx_q == IDX_W'(NSUB - 1)) begin
                        rd_bank_d = ~rd_bank_q;
                        y_idx_d   = '0;
                        y_last_d  = 1'b0;
                        // Continue straight into the other bank if it is ready.
                        if (bank_st_q[~rd_bank_q] == FULL) begin
                            y_data_d = rd_data;
                        end else begin
                            out_st_d  = IDLE;
                            y_valid_d = 1'b0;
                        end
                    end else begin
                        y_idx_d  = y_idx_q + IDX_W'(1);
                        y_data_d = rd_data;
                        y_last_d = (y_idx_q == IDX_W'(NSUB - 2));
                    end
                end
            end
            default: begin
                out_st_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt_q   <= '0;
            frame_ok_q <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            overrun_q  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                bank_st_q[b] <= EMPTY;
            end
            out_st_q   <= IDLE;
            y_valid_q  <= 1'b0;
            y_idx_q    <= '0;
            y_data_q   <= '0;
            y_last_q   <= 1'b0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            frame_ok_q <= frame_ok_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            overrun_q  <= overrun_d;
            bank_st_q  <= bank_st_d;
            out_st_q   <= out_st_d;
            y_valid_q  <= y_valid_d;
            y_idx_q    <= y_idx_d;
            y_data_q   <= y_data_d;
            y_last_q   <= y_last_d;
        end
    end

    assign y_data  = y_data_q;
    assign y_idx   = y_idx_q;
    assign y_valid = y_valid_q;
    assign y_last  = y_last_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_window_partial_sum.sv
// tb/tb_window_partial_sum.sv - randomized self-checking bench for window_partial_sum
module tb_window_partial_sum;
    import mp3_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [IN_W-1:0]  wso;
    logic                    wso_valid;
    logic signed [OUT_W-1:0] y_data;
    logic [IDX_W-1:0]        y_idx;
    logic                    y_valid;
    logic                    y_ready = 1'b0;
    logic                    y_last;
    logic                    overrun;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;   // 0: ready low, 1: ready high, 2: random ready

    typedef struct {
        int data;
        int idx;
    } beat_t;

    beat_t exp_q[$];
    int    frame_z[FRAME_LEN];

    window_partial_sum dut (
        .clk       (clk),
        .rst       (rst),
        .wso       (wso),
        .wso_valid (wso_valid),
        .y_data    (y_data),
        .y_idx     (y_idx),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_last    (y_last),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Single driver for y_ready, applied after the main process updates rdy_mode.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       y_ready = 1'b0;
            1:       y_ready = 1'b1;
            default: y_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard: every handshake must match the next expected partial sum.
    always @(negedge clk) begin
        beat_t e;
        if (rst && y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_beat", 32'(y_idx), -1);
            end else begin
                e = exp_q.pop_front();
                check_eq("y_data", 32'($signed(y_data)), e.data);
                check_eq("y_idx",  32'(y_idx), e.idx);
                check_eq("y_last", 32'(y_last), 32'(e.idx == NSUB - 1));
            end
        end
    end

    function automatic int gen(input int kind, input int n);
        case (kind)
            0:       return 16384;
            1:       return -32768;
            2:       return n;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // Reference: Y[i] is the plain sum of every 64th sample starting at i.
    task automatic push_expected();
        beat_t b;
        for (int i = 0; i < NSUB; i++) begin
            b.data = 0;
            for (int j = 0; j < NTAP; j++) begin
                b.data += frame_z[i + NSUB * j];
            end
            b.idx = i;
            exp_q.push_back(b);
        end
    endtask

    // Drives nsamp samples contiguously; leaves wso_valid high at the end.
    task automatic send_frame(input int kind, input bit expect_it, input int nsamp);
        for (int n = 0; n < FRAME_LEN; n++) begin
            frame_z[n] = gen(kind, n);
        end
        for (int n = 0; n < nsamp; n++) begin
            @(posedge clk);
            #1;
            wso       = 16'(frame_z[n]);
            wso_valid = 1'b1;
        end
        if (expect_it && nsamp == FRAME_LEN) begin
            push_expected();
        end
    endtask

    task automatic stop_input();
        @(posedge clk);
        #1;
        wso_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || y_valid) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!y_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(y_valid), 1);
    endtask

    initial begin
        logic signed [OUT_W-1:0] held_data;
        logic [IDX_W-1:0]        held_idx;

        rst       = 1'b0;
        wso       = '0;
        wso_valid = 1'b0;
        rdy_mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_y_valid", 32'(y_valid), 0);
        check_eq("rst_y_data",  32'($signed(y_data)), 0);
        check_eq("rst_y_idx",   32'(y_idx), 0);
        check_eq("rst_y_last",  32'(y_last), 0);
        check_eq("rst_overrun", 32'(overrun), 0);
        rst = 1'b1;

        // Constant, full-scale negative and ramp frames, ready always high.
        rdy_mode = 1;
        send_frame(0, 1'b1, FRAME_LEN);
        stop_input();
        wait_drain("drain_const");
        send_frame(1, 1'b1, FRAME_LEN);
        stop_input();
        wait_drain("drain_neg");
        send_frame(2, 1'b1, FRAME_LEN);
        stop_input();
        wait_drain("drain_ramp");

        // Random data, two contiguous frames, random backpressure.
        rdy_mode = 2;
        send_frame(3, 1'b1, FRAME_LEN);
        send_frame(3, 1'b1, FRAME_LEN);
        stop_input();
        wait_drain("drain_rand");

        // Ten-cycle stall with Y[5] on the bus.
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send_frame(3, 1'b1, FRAME_LEN);
        stop_input();
        wait_valid("stall_valid");
        @(posedge clk);
        #1;
        rdy_mode = 1;
        repeat (5) @(posedge clk);
        #1;
        rdy_mode = 0;
        @(negedge clk);
        check_eq("stall_idx", 32'(y_idx), 5);
        held_data = y_data;
        held_idx  = y_idx;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("stall_data", 32'($signed(y_data)), 32'($signed(held_data)));
            check_eq("stall_hidx", 32'(y_idx), 32'(held_idx));
            check_eq("stall_valid_hold", 32'(y_valid), 1);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        wait_drain("drain_stall");

        // Three back-to-back frames with ready low: the third has no bank.
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send_frame(2, 1'b1, FRAME_LEN);
        send_frame(3, 1'b1, FRAME_LEN);
        @(negedge clk);
        check_eq("overrun_before", 32'(overrun), 0);
        send_frame(0, 1'b0, FRAME_LEN);
        stop_input();
        @(negedge clk);
        check_eq("overrun_set", 32'(overrun), 1);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        for (int k = 0; k < 2 * NSUB; k++) begin
            @(negedge clk);
            check_eq("no_bubble", 32'(y_valid), 1);
        end
        @(negedge clk);
        check_eq("after_two_frames", 32'(y_valid), 0);
        check_eq("drain_two", exp_q.size(), 0);

        // Reset mid-frame with a completed frame still held at the output.
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send_frame(1, 1'b0, FRAME_LEN);
        send_frame(3, 1'b0, 300);
        @(posedge clk);
        check_eq("pre_rst_valid", 32'(y_valid), 1);
        #3;
        rst       = 1'b0;
        wso_valid = 1'b0;
        #1;
        check_eq("mid_rst_valid",   32'(y_valid), 0);
        check_eq("mid_rst_data",    32'($signed(y_data)), 0);
        check_eq("mid_rst_idx",     32'(y_idx), 0);
        check_eq("mid_rst_overrun", 32'(overrun), 0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        rdy_mode = 1;
        send_frame(3, 1'b1, FRAME_LEN);
        stop_input();
        wait_drain("drain_after_rst");
        check_eq("final_overrun", 32'(overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
